// File: rtl/uart_rx_break.sv
// uart_rx_break: 8N1 UART receiver with a one-entry holding register,
// framing-error and overrun pulses, and line-break detection. A detected
// break drives break_out, which resets the downstream command protocol.
module uart_rx_break #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int BREAK_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       data_valid,
    output logic [7:0] data,
    input  logic       data_ready,
    output logic       break_out,
    output logic       framing_error,
    output logic       overrun
);

    // BIT_CYCLES must be at least 4 so that the half-bit wait is non-trivial.
    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int BREAK_LIMIT = BREAK_BITS * BIT_CYCLES;
    localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int LOW_W       = $clog2(BREAK_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [LOW_W-1:0] LOW_LIMIT = LOW_W'(BREAK_LIMIT);
    localparam logic [LOW_W-1:0] LOW_ONE   = LOW_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK_WAIT,
        ST_BREAK,
        ST_WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rx_meta;
    logic             rxs;

    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [LOW_W-1:0] low_cnt;

    logic             timing_active;
    logic             baud_tick;
    logic             start_edge;
    logic             shift_en;
    logic             commit_set;
    logic             ferr_set;
    logic             commit_req;
    logic             flush;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign timing_active = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

    assign baud_tick = ((state == ST_START) && (baud_cnt == HALF_LAST)) ||
                       (((state == ST_DATA) || (state == ST_STOP)) && (baud_cnt == BIT_LAST));

    // State register for the frame decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and single-cycle control strobes for the datapath.
    always_comb begin
        state_next = state;
        start_edge = 1'b0;
        shift_en   = 1'b0;
        commit_set = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    start_edge = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (rxs) begin
                        commit_set = 1'b1;
                        state_next = ST_IDLE;
                    end else if (shift_reg == 8'h00) begin
                        state_next = ST_BREAK_WAIT;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rxs) begin
                    ferr_set   = 1'b1;
                    state_next = ST_IDLE;
                end else if (low_cnt >= LOW_LIMIT) begin
                    state_next = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timing: half-bit wait in START, full-bit spacing in DATA and STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (baud_tick || !timing_active) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == ST_IDLE) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {rxs, shift_reg[7:1]};
        end
    end

    // Low-time counter: starts at one because rxs was already low for a
    // cycle when IDLE saw the edge, then saturates at the break length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_cnt <= '0;
        end else if (state == ST_IDLE) begin
            low_cnt <= start_edge ? LOW_ONE : '0;
        end else if (timing_active || (state == ST_BREAK_WAIT)) begin
            if (low_cnt != LOW_LIMIT) begin
                low_cnt <= low_cnt + 1'b1;
            end
        end else begin
            low_cnt <= '0;
        end
    end

    // Commit request and framing-error pulse, one cycle after the stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_req    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            commit_req    <= commit_set;
            framing_error <= ferr_set;
        end
    end

    // Entering or holding BREAK empties the holding register in the same
    // edge, so break_out and data_valid can never be high together.
    assign flush = (state_next == ST_BREAK);

    // Holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_valid <= 1'b0;
            data       <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (flush) begin
                data_valid <= 1'b0;
            end else if (commit_req) begin
                if (!data_valid || data_ready) begin
                    data       <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign break_out = (state == ST_BREAK);

endmodule

// File: tb/tb_uart_rx_break.sv
// tb_uart_rx_break: directed self-checking bench for uart_rx_break at
// 12 MHz / 1 Mbaud (12 clocks per bit, break after 240 low clocks).
module tb_uart_rx_break;

    localparam int BITC = 12;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       data_valid;
    logic [7:0] data;
    logic       data_ready;
    logic       break_out;
    logic       framing_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int frame_start = 0;

    int valid_hi_cnt = 0;
    int last_valid_rise = -1000;
    int acc_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int last_break_rise = -1000;
    int last_break_fall = -1000;
    int both_seen = 0;
    int stable_viol = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_break = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_break #(
        .CLK_FREQ   (12000000),
        .BAUD       (1000000),
        .BREAK_BITS (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data_valid    (data_valid),
        .data          (data),
        .data_ready    (data_ready),
        .break_out     (break_out),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge and keep running tallies.
    always @(negedge clk) begin
        if (data_valid) valid_hi_cnt++;
        if (data_valid && !prev_valid) last_valid_rise = cyc;
        if (data_valid && data_ready) begin
            acc_cnt++;
            acc_data = data;
        end
        if (framing_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (break_out && !prev_break) last_break_rise = cyc;
        if (!break_out && prev_break) last_break_fall = cyc;
        if (break_out && data_valid) both_seen = 1;
        if (prev_valid && !prev_ready && data_valid && (data !== prev_data)) stable_viol++;
        prev_valid = data_valid;
        prev_ready = data_ready;
        prev_break = break_out;
        prev_data  = data;
    end

    // Time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n clocks; inputs change 2 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Send one 8N1 frame LSB first with the given stop-bit level.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
        step(1);
        rx = 1'b0;
        frame_start = cyc;
        step(BITC - 1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            rx = value[i];
            step(BITC - 1);
        end
        step(1);
        rx = stop_bit;
        step(BITC - 1);
    endtask

    initial begin
        int snap_acc;
        int snap_vhi;
        int snap_ferr;
        int snap_ovr;
        int snap_brise;
        int lat;
        logic [7:0] partial;

        reset = 1'b1;
        rx = 1'b1;
        data_ready = 1'b0;
        step(3);
        checkOutput("reset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, data}, 32'h00);
        checkOutput("reset_break", {31'd0, break_out}, 32'd0);
        checkOutput("reset_ferr", {31'd0, framing_error}, 32'd0);
        checkOutput("reset_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        step(10);

        // 0xA5 with the consumer always ready: one-cycle valid pulse.
        data_ready = 1'b1;
        snap_acc = acc_cnt; snap_vhi = valid_hi_cnt; snap_ferr = ferr_cnt; snap_ovr = ovr_cnt;
        applyStimulus(8'hA5, 1'b1);
        step(5);
        lat = last_valid_rise - frame_start;
        $display("[TB] 0xA5 latency %0d cycles", lat);
        checkOutput("a5_accepted", acc_cnt - snap_acc, 32'd1);
        checkOutput("a5_data", {24'd0, acc_data}, 32'hA5);
        checkOutput("a5_valid_width", valid_hi_cnt - snap_vhi, 32'd1);
        checkOutput("a5_latency_window", {31'd0, (lat >= 116 && lat <= 124)}, 32'd1);
        checkOutput("a5_no_ferr", ferr_cnt - snap_ferr, 32'd0);
        checkOutput("a5_no_ovr", ovr_cnt - snap_ovr, 32'd0);

        // Two back-to-back bytes with no consumer: second one overruns.
        data_ready = 1'b0;
        step(12);
        snap_acc = acc_cnt; snap_ovr = ovr_cnt;
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b1);
        step(5);
        checkOutput("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        checkOutput("ovr_data_held", {24'd0, data}, 32'h31);
        checkOutput("ovr_pulse_count", ovr_cnt - snap_ovr, 32'd1);
        checkOutput("ovr_data_stable", stable_viol, 32'd0);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        checkOutput("ovr_accept_count", acc_cnt - snap_acc, 32'd1);
        checkOutput("ovr_accept_data", {24'd0, acc_data}, 32'h31);
        checkOutput("ovr_valid_cleared", {31'd0, data_valid}, 32'd0);

        // Four-cycle low glitch on an idle line is a false start.
        step(12);
        snap_acc = acc_cnt; snap_vhi = valid_hi_cnt; snap_ferr = ferr_cnt; snap_brise = last_break_rise;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(30);
        checkOutput("glitch_no_valid", valid_hi_cnt - snap_vhi, 32'd0);
        checkOutput("glitch_no_ferr", ferr_cnt - snap_ferr, 32'd0);
        checkOutput("glitch_no_break", last_break_rise - snap_brise, 32'd0);

        // 0x55 with a low stop bit, then a clean 0x01.
        data_ready = 1'b1;
        snap_acc = acc_cnt; snap_vhi = valid_hi_cnt; snap_ferr = ferr_cnt;
        applyStimulus(8'h55, 1'b0);
        rx = 1'b1;
        step(20);
        checkOutput("ferr_pulse_count", ferr_cnt - snap_ferr, 32'd1);
        checkOutput("ferr_no_valid", valid_hi_cnt - snap_vhi, 32'd0);
        applyStimulus(8'h01, 1'b1);
        step(5);
        checkOutput("after_ferr_accept", acc_cnt - snap_acc, 32'd1);
        checkOutput("after_ferr_data", {24'd0, acc_data}, 32'h01);
        checkOutput("after_ferr_no_more_ferr", ferr_cnt - snap_ferr, 32'd1);

        // Reset in the middle of the data bits of 0x7E, then a clean 0x42.
        step(12);
        snap_acc = acc_cnt; snap_ferr = ferr_cnt;
        partial = 8'h7E;
        step(1);
        rx = 1'b0;
        step(BITC - 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            rx = partial[i];
            step(BITC - 1);
        end
        reset = 1'b1;
        rx = 1'b1;
        step(2);
        checkOutput("midreset_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("midreset_data", {24'd0, data}, 32'h00);
        checkOutput("midreset_break", {31'd0, break_out}, 32'd0);
        reset = 1'b0;
        step(36);
        checkOutput("midreset_no_spurious", acc_cnt - snap_acc, 32'd0);
        applyStimulus(8'h42, 1'b1);
        step(5);
        checkOutput("midreset_next_count", acc_cnt - snap_acc, 32'd1);
        checkOutput("midreset_next_data", {24'd0, acc_data}, 32'h42);
        checkOutput("midreset_no_ferr", ferr_cnt - snap_ferr, 32'd0);

        // Break of 300 low cycles while a byte is pending.
        data_ready = 1'b0;
        step(12);
        applyStimulus(8'h99, 1'b1);
        step(5);
        checkOutput("break_pending_valid", {31'd0, data_valid}, 32'd1);
        snap_acc = acc_cnt; snap_ferr = ferr_cnt;
        step(1);
        rx = 1'b0;
        frame_start = cyc;
        step(299);
        lat = last_break_rise - frame_start;
        $display("[TB] break rise %0d cycles after edge", lat);
        checkOutput("break_high", {31'd0, break_out}, 32'd1);
        checkOutput("break_flushed_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("break_rise_window", {31'd0, (lat >= 238 && lat <= 246)}, 32'd1);
        checkOutput("break_no_ferr", ferr_cnt - snap_ferr, 32'd0);
        rx = 1'b1;
        frame_start = cyc;
        step(8);
        lat = last_break_fall - frame_start;
        checkOutput("break_fall_window", {31'd0, (lat >= 2 && lat <= 3)}, 32'd1);
        checkOutput("break_low_after", {31'd0, break_out}, 32'd0);
        data_ready = 1'b1;
        step(24);
        checkOutput("break_no_stale_accept", acc_cnt - snap_acc, 32'd0);
        applyStimulus(8'h00, 1'b1);
        step(5);
        checkOutput("zero_after_break_count", acc_cnt - snap_acc, 32'd1);
        checkOutput("zero_after_break_data", {24'd0, acc_data}, 32'h00);

        checkOutput("never_break_and_valid", both_seen, 32'd0);
        checkOutput("data_stable_overall", stable_viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
